// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one DW-bit vector/scalar ALU between two requesters:
//     port 0 = pipeline execute stage, port 1 = vector co-processing engine.
//   A request is granted only while IDLE. The granted operands are registered
//   onto alu_opa/alu_opb/alu_ctrl and held for ALU_LATENCY cycles. The ALU
//   result/flags are then captured and returned on the owner's valid/ready
//   response channel. Sequence: IDLE -> EXEC -> RESP -> IDLE.
//
//   Configuration macro: ALU_ARB_FIXED_PRIO_EN
//     defined   : port 0 always wins a tie (no round-robin pointer; port 1 may starve)
//     undefined : round-robin tie-break, at most one op of waiting per port
module alu_share_arbiter #(
  parameter int ALU_LATENCY = 2,
  parameter int DW          = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  // request port 0 (execute stage)
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_opa,
  input  logic [DW-1:0] req0_opb,
  input  logic [2:0]    req0_op,
  // request port 1 (vector engine)
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_opa,
  input  logic [DW-1:0] req1_opb,
  input  logic [2:0]    req1_op,
  // response port 0
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_result,
  output logic [3:0]    rsp0_flags,
  // response port 1
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_result,
  output logic [3:0]    rsp1_flags,
  // shared ALU
  output logic [DW-1:0] alu_opa,
  output logic [DW-1:0] alu_opb,
  output logic [2:0]    alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_flags,
  // status
  output logic          busy
);

  // A zero-latency ALU cannot be served by the EXEC hold phase.
  if (ALU_LATENCY < 1) begin : g_bad_latency
    $error("alu_share_arbiter: ALU_LATENCY must be >= 1");
  end

  // cnt only has to reach ALU_LATENCY-1.
  localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LATENCY - 1);
  localparam logic [2:0]    CTRL_RST = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          owner_r;
  logic [CW-1:0] cnt_r;
  logic          grant_valid_s;
  logic          grant_port_s;
  logic          accept_s;
  logic          exec_done_s;
  logic          owner_ready_s;
  logic          rsp_done_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic          rr_ptr_r;
`endif

  // Grant selection: a single valid port wins outright; a tie goes to the
  // round-robin pointer, or to port 0 in the fixed-priority build.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_port_s  = 1'b0;
`else
      grant_port_s  = rr_ptr_r;
`endif
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
  end

  // Handshake qualifiers derived from the current state.
  always_comb begin
    accept_s      = (state_r == IDLE) && grant_valid_s;
    exec_done_s   = (state_r == EXEC) && (cnt_r == CNT_LAST);
    owner_ready_s = owner_r ? rsp1_ready : rsp0_ready;
    rsp_done_s    = (state_r == RESP) && owner_ready_s;
  end

  // Ready is only offered in IDLE, and only to the granted port.
  always_comb begin
    req0_ready = accept_s && (grant_port_s == 1'b0);
    req1_ready = accept_s && (grant_port_s == 1'b1);
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (exec_done_s) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; busy is registered alongside so it mirrors state != IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after a grant, the other port gets the next tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= 1'b0;
    end else if (accept_s) begin
      rr_ptr_r <= ~grant_port_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // ALU operand registers: loaded only on an accept edge, held otherwise so
  // the ALU sees stable inputs for its whole latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opa <= {DW{1'b0}};
      alu_opb <= {DW{1'b0}};
      alu_ctrl <= CTRL_RST;
      owner_r <= 1'b0;
    end else if (accept_s) begin
      alu_opa  <= grant_port_s ? req1_opa : req0_opa;
      alu_opb  <= grant_port_s ? req1_opb : req0_opb;
      alu_ctrl <= grant_port_s ? req1_op  : req0_op;
      owner_r  <= grant_port_s;
    end else begin
      alu_opa  <= alu_opa;
      alu_opb  <= alu_opb;
      alu_ctrl <= alu_ctrl;
      owner_r  <= owner_r;
    end
  end

  // EXEC cycle counter: cleared on accept, advanced every EXEC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == EXEC) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response port 0: capture on the last EXEC edge if port 0 owns the op,
  // drop valid on the handshake edge. Data stays put between captures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= {DW{1'b0}};
      rsp0_flags  <= 4'b0000;
    end else if (exec_done_s && (owner_r == 1'b0)) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_flags  <= alu_flags;
    end else if (rsp_done_s && (owner_r == 1'b0)) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= rsp0_result;
      rsp0_flags  <= rsp0_flags;
    end else begin
      rsp0_valid  <= rsp0_valid;
      rsp0_result <= rsp0_result;
      rsp0_flags  <= rsp0_flags;
    end
  end

  // Response port 1: same behaviour as port 0, keyed on owner == 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= {DW{1'b0}};
      rsp1_flags  <= 4'b0000;
    end else if (exec_done_s && (owner_r == 1'b1)) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_flags  <= alu_flags;
    end else if (rsp_done_s && (owner_r == 1'b1)) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= rsp1_result;
      rsp1_flags  <= rsp1_flags;
    end else begin
      rsp1_valid  <= rsp1_valid;
      rsp1_result <= rsp1_result;
      rsp1_flags  <= rsp1_flags;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed steps followed by a random phase. A timeline model tracks when
//   each accepted op must return (accept cycle + ALU_LATENCY + 1) and what it
//   must return. A combinational stand-in drives the ALU result from the held
//   operands. Honours ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_share_arbiter;
  localparam int L  = 2;
  localparam int DW = 48;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [3:0]    rsp0_flags, rsp1_flags;
  logic [DW-1:0] alu_opa, alu_opb, alu_result;
  logic [2:0]    alu_ctrl;
  logic [3:0]    alu_flags;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit            m_idle;
  bit            m_owner;
  bit            m_last;
  int            m_rsp_cycle;
  int            cyc;
  logic [DW-1:0] m_res [2];
  logic [3:0]    m_flg [2];
  logic [DW-1:0] m_pres;
  logic [3:0]    m_pflg;
  logic [DW-1:0] m_a, m_b;
  logic [2:0]    m_c;
  int            grant_log [$];
  int            acc_log [$];

  alu_share_arbiter #(.ALU_LATENCY(L), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
    .req0_opb(req0_opb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
    .req1_opb(req1_opb), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {flags, result}. CMP sets flags {a<b, a==b, 0, 0}.
  function automatic logic [51:0] alu_fn(input logic [2:0] op,
                                         input logic [47:0] a,
                                         input logic [47:0] b);
    logic [47:0] r;
    logic [3:0]  f;
    logic [95:0] p;
    p = {48'd0, a} * {48'd0, b};
    r = 48'd0;
    case (op)
      3'b000: begin
        r[47:32] = a[47:32] + b[47:32];
        r[31:16] = a[31:16] + b[31:16];
        r[15:0]  = a[15:0]  + b[15:0];
      end
      3'b001: r = a & b;
      3'b010: r = a | b;
      3'b011: r = a ^ b;
      3'b101: r = a - b;
      3'b110: r = p[47:0];
      default: r = 48'd0;
    endcase
    if (op == 3'b100) f = {(a < b), (a == b), 2'b00};
    else              f = {r[47], (r == 48'd0), 2'b00};
    return {f, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_opa, alu_opb);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle   = 1'b1;
    m_owner  = 1'b0;
    m_last   = 1'b1;   // next tie goes to port 0
    m_res[0] = '0; m_res[1] = '0;
    m_flg[0] = '0; m_flg[1] = '0;
    m_a = '0; m_b = '0; m_c = 3'b111;
  endtask

  // One clock cycle: settle, compare every output to the model, advance the
  // model with this cycle's inputs, then move to just after the next edge.
  task automatic step();
    bit g_ok;
    bit g;
    bit rsp_on;
    logic [51:0] fr;
    #1;
    g_ok = 1'b0;
    g    = 1'b0;
    if (m_idle) begin
      if (req0_valid && req1_valid) begin
        g_ok = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~m_last;
`endif
      end else if (req0_valid) begin
        g_ok = 1'b1; g = 1'b0;
      end else if (req1_valid) begin
        g_ok = 1'b1; g = 1'b1;
      end
    end
    rsp_on = !m_idle && (cyc >= m_rsp_cycle);
    if (rsp_on && cyc == m_rsp_cycle) begin
      m_res[m_owner] = m_pres;
      m_flg[m_owner] = m_pflg;
    end
    chk("req0_ready", 64'(req0_ready), 64'(g_ok && !g));
    chk("req1_ready", 64'(req1_ready), 64'(g_ok && g));
    chk("busy", 64'(busy), 64'(!m_idle));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(rsp_on && !m_owner));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(rsp_on && m_owner));
    chk("rsp0_result", 64'(rsp0_result), 64'(m_res[0]));
    chk("rsp1_result", 64'(rsp1_result), 64'(m_res[1]));
    chk("rsp0_flags", 64'(rsp0_flags), 64'(m_flg[0]));
    chk("rsp1_flags", 64'(rsp1_flags), 64'(m_flg[1]));
    chk("alu_opa", 64'(alu_opa), 64'(m_a));
    chk("alu_opb", 64'(alu_opb), 64'(m_b));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(m_c));
    if (!rst_n) begin
      model_reset();
    end else if (g_ok) begin
      m_idle  = 1'b0;
      m_owner = g;
      m_last  = g;
      m_a = g ? req1_opa : req0_opa;
      m_b = g ? req1_opb : req0_opb;
      m_c = g ? req1_op  : req0_op;
      fr = alu_fn(m_c, m_a, m_b);
      m_pres = fr[47:0];
      m_pflg = fr[51:48];
      m_rsp_cycle = cyc + L + 1;
      grant_log.push_back(int'(g));
      acc_log.push_back(cyc);
    end else if (rsp_on && (m_owner ? rsp1_ready : rsp0_ready)) begin
      m_idle = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (L + 4) step();
  endtask

  initial begin
    logic [51:0] e;
    int t0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opa = '0; req0_opb = '0; req0_op = 3'b000;
    req1_opa = '0; req1_opb = '0; req1_op = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    cyc = 0;
    m_rsp_cycle = 0;
    m_pres = '0; m_pflg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset values
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(3'b111));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'(1'b0));
    step();
    rst_n = 1'b1;

    // test 1: lane-wise vsum on port 0
    req0_valid = 1'b1; req0_op = 3'b000;
    req0_opa = {16'd1, 16'd2, 16'd3};
    req0_opb = {16'd4, 16'd5, 16'd6};
    rsp0_ready = 1'b1;
    t0 = cyc;
    step();
    req0_valid = 1'b0;
    step();
    step();
    chk("t1_cycle3", 64'(cyc - t0), 64'(3));
    chk("t1_rsp0_valid", 64'(rsp0_valid), 64'(1'b1));
    chk("t1_rsp0_result", 64'(rsp0_result), 64'({16'd5, 16'd7, 16'd9}));
    chk("t1_rsp1_valid", 64'(rsp1_valid), 64'(1'b0));
    step();
    step();

    // test 2 (and 6 in the fixed-priority build): both held valid after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_log.delete();
    acc_log.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 3'b001; req1_op = 3'b010;
    req0_opa = 48'h0000_ffff_0f0f; req0_opb = 48'h1234_5678_9abc;
    req1_opa = 48'h00f0_0000_1111; req1_opb = 48'h0f00_2222_0000;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4 * (L + 2) + 1) step();
    chk("t2_n_grants", 64'(grant_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t6_grant_port0", 64'(grant_log[i]), 64'(0));
`else
      chk("t2_grant_alternate", 64'(grant_log[i]), 64'(i % 2));
`endif
    end
    chk("t2_issue_interval", 64'(acc_log[1] - acc_log[0]), 64'(L + 2));
    drain();

    // test 3: port 1 response held off for 5 cycles while port 0 waits
    req1_valid = 1'b1; req1_op = 3'b101;
    req1_opa = 48'h0000_0000_1000; req1_opb = 48'h0000_0000_0001;
    e = alu_fn(3'b101, 48'h0000_0000_1000, 48'h0000_0000_0001);
    rsp1_ready = 1'b0;
    step();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 3'b011;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_rsp1_valid", 64'(rsp1_valid), 64'(1'b1));
      chk("t3_rsp1_result", 64'(rsp1_result), 64'(e[47:0]));
      chk("t3_rsp1_flags", 64'(rsp1_flags), 64'(e[51:48]));
      chk("t3_busy", 64'(busy), 64'(1'b1));
      chk("t3_req0_ready", 64'(req0_ready), 64'(1'b0));
      step();
    end
    rsp1_ready = 1'b1;
    step();
    #1;
    chk("t3_idle_busy", 64'(busy), 64'(1'b0));
    chk("t3_idle_req0_ready", 64'(req0_ready), 64'(1'b1));
    req0_valid = 1'b0;
    drain();

    // test 4: reset during EXEC aborts the op
    req0_valid = 1'b1; req0_op = 3'b110;
    req0_opa = 48'd12345; req0_opb = 48'd678;
    step();
    req0_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t4_alu_ctrl", 64'(alu_ctrl), 64'(3'b111));
    chk("t4_alu_opa", 64'(alu_opa), 64'(0));
    chk("t4_busy", 64'(busy), 64'(1'b0));
    chk("t4_rsp0_result", 64'(rsp0_result), 64'(0));
    repeat (L + 3) step();

    // test 5: CMP equal on port 1
    req1_valid = 1'b1; req1_op = 3'b100;
    req1_opa = 48'd7; req1_opb = 48'd7;
    rsp1_ready = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    step();
    chk("t5_rsp1_valid", 64'(rsp1_valid), 64'(1'b1));
    chk("t5_rsp1_result", 64'(rsp1_result), 64'(0));
    chk("t5_rsp1_flags", 64'(rsp1_flags), 64'(4'b0100));
    drain();

    // random phase
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_op  = 3'($urandom_range(0, 7));
      req1_op  = 3'($urandom_range(0, 7));
      req0_opa = 48'({$urandom(), $urandom()});
      req0_opb = 48'({$urandom(), $urandom()});
      req1_opa = 48'({$urandom(), $urandom()});
      req1_opb = 48'({$urandom(), $urandom()});
      rsp0_ready = ($urandom_range(0, 1) == 1);
      rsp1_ready = ($urandom_range(0, 1) == 1);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
